// File: rtl/pool1_layer.sv
`default_nettype none
// pool1_layer: ReLU followed by 2x2 stride-2 max pooling over a raster pixel stream, all channels in parallel.
// Revision: 1.0
module pool1_layer #(
  parameter int IN_W      = 26,
  parameter int IN_H      = 34,
  parameter int CH        = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_BITS-1:0] data_in [0:CH-1],
  input  logic                        valid_in,
  output logic signed [DATA_BITS-1:0] pool_out [0:CH-1],
  output logic                        valid_out,
  output logic                        frame_done
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int LB_D  = (OUT_W > 0) ? OUT_W : 1;
  localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int LW    = (LB_D > 1) ? $clog2(LB_D) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IN_H - 1);
  localparam logic [CW-1:0] COL_WIN_LAST = CW'(2 * OUT_W - 1);
  localparam logic [RW-1:0] ROW_WIN_LAST = RW'(2 * OUT_H - 1);
  localparam bit            H_ODD        = (IN_H % 2) == 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] lb_idx;
  logic          hold_wr;
  logic          lb_wr;
  logic          pool_beat;
  logic          last_win;

  logic signed [DATA_BITS-1:0] hold     [0:CH-1];
  logic signed [DATA_BITS-1:0] linebuf  [0:CH-1][0:LB_D-1];
  logic signed [DATA_BITS-1:0] relu     [0:CH-1];
  logic signed [DATA_BITS-1:0] pair_max [0:CH-1];
  logic signed [DATA_BITS-1:0] win_max  [0:CH-1];

  assign lb_idx    = LW'(col >> 1);
  assign hold_wr   = valid_in && !col[0];
  assign pool_beat = valid_in && col[0] && row[0];
  // An unpaired trailing row (odd IN_H) is consumed but never stored.
  assign lb_wr     = valid_in && col[0] && !row[0] && !(H_ODD && (row == ROW_LAST));
  assign last_win  = (row == ROW_WIN_LAST) && (col == COL_WIN_LAST);

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      relu[c]     = data_in[c][DATA_BITS-1] ? '0 : data_in[c];
      pair_max[c] = (hold[c] > relu[c]) ? hold[c] : relu[c];
      win_max[c]  = (linebuf[c][lb_idx] > pair_max[c]) ? linebuf[c][lb_idx] : pair_max[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        hold[c]     <= '0;
        pool_out[c] <= '0;
      end
    end else begin
      valid_out  <= pool_beat;
      frame_done <= pool_beat && last_win;
      for (int c = 0; c < CH; c++) begin
        if (hold_wr)   hold[c]     <= relu[c];
        if (pool_beat) pool_out[c] <= win_max[c];
      end
    end
  end

  // Line buffer holds data only between an even row and its odd partner; no reset needed.
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      for (int c = 0; c < CH; c++) linebuf[c][lb_idx] <= pair_max[c];
    end
  end

endmodule
`default_nettype wire
